// File: rtl/temperature_alarm_monitor.sv
// Temperature alarm monitor.
// Consumes per-sample abnormality verdicts from the temperature analyzer.
// Short abnormal bursts are filtered out by a persistence counter.
// A sustained abnormal condition raises a latched alarm that the host must
// acknowledge. The block also tracks the peak temperature of each episode and
// keeps a saturating count of alarm episodes.
module temperature_alarm_monitor #(
  parameter int ALARM_COUNT = 4,  // consecutive abnormal samples to raise alarm (1..15)
  parameter int CLEAR_COUNT = 3   // consecutive normal samples to clear (1..15)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sampleValid,
  input  logic [7:0] temperature,
  input  logic       temperatureAbnormality,
  input  logic       alarmAck,
  output logic       alarm,
  output logic [1:0] alarmState,
  output logic [7:0] peakTemperature,
  output logic [7:0] alarmEvents
);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    SUSPECT = 2'd1,
    ALARM   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [3:0] ALARM_TH = 4'(ALARM_COUNT);
  localparam logic [3:0] CLEAR_TH = 4'(CLEAR_COUNT);

  state_t     state, state_nx;
  logic [3:0] abn_run, abn_run_nx;
  logic [3:0] ok_run, ok_run_nx;
  logic       ack_seen, ack_seen_nx;
  logic [7:0] peak_nx;
  logic [7:0] events_nx;

  logic       abn, ok;
  logic [7:0] peak_max;
  logic [7:0] events_inc;
  logic [3:0] abn_run_inc, ok_run_inc;

  // Qualified sample classes, running peak and saturating increments.
  assign abn         = sampleValid & temperatureAbnormality;
  assign ok          = sampleValid & ~temperatureAbnormality;
  assign peak_max    = (temperature > peakTemperature) ? temperature : peakTemperature;
  assign events_inc  = (alarmEvents == 8'hFF) ? 8'hFF : 8'(alarmEvents + 8'd1);
  // Run counters stay at or below their thresholds (<= 15), so +1 never wraps.
  assign abn_run_inc = 4'(abn_run + 4'd1);
  assign ok_run_inc  = 4'(ok_run + 4'd1);

  assign alarmState  = state;

  // Next-state and next-value logic for the episode FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nx    = state;
    abn_run_nx  = abn_run;
    ok_run_nx   = ok_run;
    ack_seen_nx = ack_seen;
    peak_nx     = peakTemperature;
    events_nx   = alarmEvents;

    unique case (state)
      NORMAL: begin
        if (abn) begin
          abn_run_nx = 4'd1;
          peak_nx    = temperature;  // new episode restarts the peak
          if (ALARM_TH == 4'd1) begin
            state_nx    = ALARM;
            events_nx   = events_inc;
            ok_run_nx   = 4'd0;
            ack_seen_nx = 1'b0;
          end else begin
            state_nx = SUSPECT;
          end
        end
      end

      SUSPECT: begin
        if (abn) begin
          peak_nx    = peak_max;
          abn_run_nx = abn_run_inc;
          if (abn_run_inc >= ALARM_TH) begin
            state_nx    = ALARM;
            events_nx   = events_inc;
            ok_run_nx   = 4'd0;
            ack_seen_nx = 1'b0;
          end
        end else if (ok) begin
          state_nx   = NORMAL;
          abn_run_nx = 4'd0;  // peak is intentionally held
        end
      end

      ALARM: begin
        if (alarmAck) ack_seen_nx = 1'b1;
        if (abn) begin
          ok_run_nx = 4'd0;
          peak_nx   = peak_max;
        end else if (ok) begin
          if (ok_run_inc >= CLEAR_TH) begin
            if (ack_seen || alarmAck) begin
              state_nx    = NORMAL;
              abn_run_nx  = 4'd0;
              ok_run_nx   = 4'd0;
              ack_seen_nx = 1'b0;
            end else begin
              state_nx  = HOLD;
              ok_run_nx = CLEAR_TH;
            end
          end else begin
            ok_run_nx = ok_run_inc;
          end
        end
      end

      HOLD: begin
        // A fresh abnormal sample beats a simultaneous ack: same episode resumes.
        if (abn) begin
          state_nx    = ALARM;
          ok_run_nx   = 4'd0;
          ack_seen_nx = 1'b0;
          peak_nx     = peak_max;
        end else if (alarmAck) begin
          state_nx    = NORMAL;
          abn_run_nx  = 4'd0;
          ok_run_nx   = 4'd0;
          ack_seen_nx = 1'b0;
        end
      end

      default: state_nx = NORMAL;
    endcase
  end

  // State and output registers; asynchronous reset returns everything to idle.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    if (reset) begin
      state           <= NORMAL;
      abn_run         <= 4'd0;
      ok_run          <= 4'd0;
      ack_seen        <= 1'b0;
      peakTemperature <= 8'd0;
      alarmEvents     <= 8'd0;
      alarm           <= 1'b0;
    end else begin
      state           <= state_nx;
      abn_run         <= abn_run_nx;
      ok_run          <= ok_run_nx;
      ack_seen        <= ack_seen_nx;
      peakTemperature <= peak_nx;
      alarmEvents     <= events_nx;
      alarm           <= (state_nx == ALARM) || (state_nx == HOLD);
    end
  end

endmodule

// File: doc/temperature_alarm_monitor.md
Name: temperature_alarm_monitor

Overview:
- Sits downstream of the combinational temperature analyzer and consumes its per-sample `temperatureAbnormality` flag together with the sampled 8-bit temperature.
- Filters transient abnormal readings with a persistence counter.
- Raises a latched `alarm` that software must acknowledge, and records the episode's peak temperature and a saturating alarm-episode count.

Parameters:
- ALARM_COUNT, 4: consecutive abnormal samples required to raise the alarm (legal range 1..15).
- CLEAR_COUNT, 3: consecutive normal samples required to consider the condition cleared (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sampleValid  input  1  one-cycle strobe; temperature and temperatureAbnormality are valid this cycle.
- temperature  input  8  unsigned sampled temperature.
- temperatureAbnormality  input  1  analyzer verdict for this sample (1 = out of range).
- alarmAck  input  1  one-cycle acknowledge from the host.
- alarm  output  1  latched alarm indication.
- alarmState  output  2  FSM state: 0 NORMAL, 1 SUSPECT, 2 ALARM, 3 HOLD.
- peakTemperature  output  8  highest abnormal temperature in the current or most recent episode.
- alarmEvents  output  8  count of alarm episodes, saturates at 255.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: alarm=0, alarmState=NORMAL, peakTemperature=0, alarmEvents=0. Internal state also resets: abnRun=0, okRun=0, ackSeen=0.
- Reset asserted mid-episode returns the block to these values immediately, without waiting for a clock edge.
- All outputs are registered. Effects of a sample or ack are visible the cycle after the strobe.
- Inputs are ignored when sampleValid=0, except alarmAck, which is honoured on any cycle.
- "abn" below means sampleValid=1 and temperatureAbnormality=1. "ok" means sampleValid=1 and temperatureAbnormality=0.
- NORMAL:
  - abn -> abnRun=1 and peakTemperature=temperature (new episode).
  - If ALARM_COUNT==1, go to ALARM and increment alarmEvents; otherwise go to SUSPECT.
  - ok -> stay in NORMAL.
  - alarmAck has no effect.
- SUSPECT:
  - abn -> abnRun++ and peak=max(peak,temperature).
  - When abnRun reaches ALARM_COUNT, go to ALARM, increment alarmEvents (saturating), okRun=0, ackSeen=0.
  - ok -> go to NORMAL, abnRun=0. peakTemperature is held.
- ALARM (alarm=1):
  - abn -> okRun=0, peak=max(peak,temperature).
  - ok -> okRun++.
  - alarmAck -> ackSeen=1.
  - When okRun reaches CLEAR_COUNT: if ackSeen=1 or alarmAck is asserted the same cycle, go to NORMAL and clear alarm; otherwise go to HOLD.
- HOLD (alarm=1, condition cleared, awaiting ack):
  - alarmAck -> go to NORMAL, alarm=0.
  - abn -> go back to ALARM, okRun=0, ackSeen=0, peak=max. alarmEvents does NOT increment (same episode).
  - If alarmAck and abn arrive in the same cycle, abn wins: go to ALARM and drop the ack.
  - ok -> stay in HOLD.
- Counters abnRun and okRun are 4 bits wide and only count up to their thresholds; they never wrap.
- On leaving ALARM/HOLD for NORMAL, abnRun, okRun and ackSeen are all cleared.
- alarm is asserted exactly when alarmState is ALARM or HOLD.
- alarmEvents holds at 255 once reached; it is never cleared except by reset.
- peakTemperature comparisons are unsigned 8-bit. A temperature of 255 is a legal value and is captured.

Test Plan:
- Reset, then 4 abn samples at temperatures 36,40,38,37, with gaps of 2 idle cycles between strobes:
  - alarmState goes 1,1,1,2; alarm rises 1 cycle after the 4th strobe.
  - peakTemperature=40, alarmEvents=1.
- 3 abn samples then 1 ok sample:
  - state returns to NORMAL, alarm never asserted, alarmEvents unchanged.
  - peakTemperature holds the max of the 3 samples.
- Continuing from the alarm: alarmAck pulsed while in ALARM, then 3 ok samples -> direct ALARM->NORMAL, alarm=0 one cycle after the 3rd ok sample.
- From ALARM, 3 ok samples with no ack:
  - state=HOLD, alarm stays 1.
  - Next abn sample at 45 -> ALARM, peak=45, alarmEvents unchanged.
  - Then 3 ok samples, then alarmAck -> NORMAL.
- In HOLD, assert alarmAck and an abn sample in the same cycle -> state=ALARM, alarm=1.
- Assert reset asynchronously mid-ALARM, between clock edges -> all outputs zero immediately.
- With ALARM_COUNT=1, 256 alarm episodes -> alarmEvents saturates at 255.
